// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO word packer: state encoding, default
// geometry and lane-counter sizing.
package fifo_pkg;

  localparam int DEF_SIZE_DATA  = 8;
  localparam int DEF_PACK_RATIO = 4;
  localparam int CNT_W          = $clog2(DEF_PACK_RATIO + 1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_XFER = 1'b1;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Pops FIFO entries and packs PACK_RATIO of them into one wide word with a
// valid/ready output; a flush request emits a partially filled word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int SIZE_DATA  = DEF_SIZE_DATA,
  parameter int PACK_RATIO = DEF_PACK_RATIO
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_fifo_empty,
  input  logic [SIZE_DATA-1:0]            i_fifo_data,
  output logic                            o_fifo_rd_en,
  input  logic                            i_flush,
  output logic [SIZE_DATA*PACK_RATIO-1:0] o_data,
  output logic [PACK_RATIO-1:0]           o_keep,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_busy
);

  localparam int LCNT_W = cnt_width(PACK_RATIO);
  localparam int WORD_W = SIZE_DATA * PACK_RATIO;

  logic [0:0]            state_q, state_d;
  logic [LCNT_W-1:0]     cnt_q, cnt_d;
  logic                  inflight_q, inflight_d;
  logic                  flush_pend_q, flush_pend_d;
  logic [WORD_W-1:0]     asm_q, asm_d;
  logic [WORD_W-1:0]     data_q, data_d;
  logic [PACK_RATIO-1:0] keep_q, keep_d;
  logic                  valid_q, valid_d;
  logic                  rd_en;
  logic                  xfer;

  assign rd_en = !i_rst && !i_fifo_empty && (state_q == S_FILL) &&
                 ((int'(cnt_q) + int'(inflight_q)) < PACK_RATIO) && !flush_pend_q;
  assign xfer  = (state_q == S_XFER) && (!valid_q || i_ready);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    inflight_d   = rd_en;
    flush_pend_d = flush_pend_q | i_flush;
    asm_d        = asm_q;
    data_d       = data_q;
    keep_d       = keep_q;
    valid_d      = valid_q;
    if (valid_q && i_ready) valid_d = 1'b0;
    if (state_q == S_FILL) begin
      if (inflight_q) begin
        asm_d[int'(cnt_q)*SIZE_DATA +: SIZE_DATA] = i_fifo_data;
        cnt_d = cnt_q + LCNT_W'(1);
      end
      // Decide on the post-capture count so a full word moves on the very next cycle.
      if (int'(cnt_d) == PACK_RATIO) begin
        state_d = S_XFER;
      end else if (flush_pend_d && !inflight_d) begin
        if (cnt_d != '0) state_d = S_XFER;
        else             flush_pend_d = 1'b0;
      end
    end else if (xfer) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        keep_d[i] = (i < int'(cnt_q));
        data_d[i*SIZE_DATA +: SIZE_DATA] = keep_d[i] ? asm_q[i*SIZE_DATA +: SIZE_DATA]
                                                     : '0;
      end
      valid_d      = 1'b1;
      cnt_d        = '0;
      flush_pend_d = 1'b0;
      state_d      = S_FILL;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_FILL;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      keep_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      flush_pend_q <= flush_pend_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
    end
  end

  // Stale lanes are masked on transfer, so the assembly register needs no reset.
  always_ff @(posedge i_clk) begin
    asm_q <= asm_d;
  end

  assign o_fifo_rd_en = rd_en;
  assign o_data       = data_q;
  assign o_keep       = keep_q;
  assign o_valid      = valid_q;
  assign o_busy       = !i_rst && ((cnt_q != '0) || inflight_q || valid_q);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: FIFO model, word-grouping reference model,
// scoreboard monitor, directed scenarios and a randomized phase.
module tb_fifo_word_packer;

  localparam int SD = 8;
  localparam int PR = 4;
  localparam int W  = SD * PR;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [SD-1:0] fifo_data = '0;
  logic          rd_en;
  logic          flush = 1'b0;
  logic [W-1:0]  data;
  logic [PR-1:0] keep;
  logic          valid;
  logic          ready = 1'b0;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [SD-1:0] fifo_q[$];
  logic [SD-1:0] pend_q[$];
  logic [W-1:0]  exp_data_q[$];
  logic [PR-1:0] exp_keep_q[$];
  logic [SD-1:0] nxt_data = '0;

  int cyc = 0;
  int rd_cycles, valid_cycles, first_rd, first_vld;
  logic [W-1:0]  last_data;
  logic [PR-1:0] last_keep;

  always #5 clk = ~clk;

  fifo_word_packer #(.SIZE_DATA(SD), .PACK_RATIO(PR)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fifo_empty(fifo_empty),
    .i_fifo_data (fifo_data),
    .o_fifo_rd_en(rd_en),
    .i_flush     (flush),
    .o_data      (data),
    .o_keep      (keep),
    .o_valid     (valid),
    .i_ready     (ready),
    .o_busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Reference: every entry popped joins the pending word; a word is complete
  // after PR entries or when a flush finds a non-empty pending word.
  task automatic emit();
    logic [W-1:0]  w = '0;
    logic [PR-1:0] k = '0;
    for (int i = 0; i < pend_q.size(); i++) begin
      w[i*SD +: SD] = pend_q[i];
      k[i] = 1'b1;
    end
    exp_data_q.push_back(w);
    exp_keep_q.push_back(k);
    pend_q.delete();
  endtask

  task automatic mark();
    rd_cycles    = 0;
    valid_cycles = 0;
    first_rd     = -1;
    first_vld    = -1;
    last_data    = '0;
    last_keep    = '0;
  endtask

  task automatic step(input logic f, input logic r, input logic rs);
    @(negedge clk);
    rst        = rs;
    flush      = f;
    ready      = r;
    fifo_data  = nxt_data;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    cyc++;
    if (rs) begin
      fifo_q.delete();
      pend_q.delete();
      exp_data_q.delete();
      exp_keep_q.delete();
      nxt_data = '0;
    end else begin
      if (rd_en) begin
        rd_cycles++;
        if (first_rd < 0) first_rd = cyc;
        check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        if (fifo_q.size() != 0) begin
          nxt_data = fifo_q.pop_front();
          pend_q.push_back(nxt_data);
          if (pend_q.size() == PR) emit();
        end
      end
      if (f && pend_q.size() > 0) emit();
      if (valid) begin
        valid_cycles++;
        if (first_vld < 0) first_vld = cyc;
        last_data = data;
        last_keep = keep;
      end
    end
  endtask

  // Scoreboard monitor: every presented word must match the head of the
  // expected queue; the head is retired on acceptance.
  always @(negedge clk) begin
    #2;
    if (rst === 1'b0 && valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word got=%0h expected=none", data);
      end else begin
        check("sb_data", 64'(data), 64'(exp_data_q[0]));
        check("sb_keep", 64'(keep), 64'(exp_keep_q[0]));
        if (ready) begin
          void'(exp_data_q.pop_front());
          void'(exp_keep_q.pop_front());
        end
      end
    end
  end

  initial begin
    mark();
    step(0, 1, 1);
    step(0, 1, 1);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_data",  64'(data),  64'd0);
    check("rst_keep",  64'(keep),  64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_rd_en", 64'(rd_en), 64'd0);

    // Full word with free sink
    mark();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    check("t1_rd_cycles", 64'(rd_cycles), 64'd4);
    check("t1_valid_cycles", 64'(valid_cycles), 64'd1);
    check("t1_latency", 64'(first_vld - first_rd), 64'(PR + 2));
    check("t1_data", 64'(last_data), 64'h44332211);
    check("t1_keep", 64'(last_keep), 64'hF);

    // Backpressure: two words, sink stalled
    mark();
    fifo_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 14; i++) step(0, 0, 0);
    check("t2_rd_cycles", 64'(rd_cycles), 64'd8);
    check("t2_held_valid", 64'(valid), 64'd1);
    check("t2_held_data", 64'(data), 64'h44332211);
    check("t2_busy", 64'(busy), 64'd1);
    fifo_q.push_back(8'h99);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    check("t2_no_more_reads", 64'(rd_cycles), 64'd8);
    step(0, 1, 0);
    check("t2_word1_valid", 64'(valid), 64'd1);
    check("t2_word1_data", 64'(data), 64'h44332211);
    step(0, 1, 0);
    check("t2_word2_valid", 64'(valid), 64'd1);
    check("t2_word2_data", 64'(data), 64'h88776655);
    check("t2_word2_keep", 64'(keep), 64'hF);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0);

    // Partial word flush
    mark();
    fifo_q = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 6; i++) step(0, 1, 0);
    check("t3_no_early_word", 64'(valid_cycles), 64'd0);
    step(1, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    check("t3_valid_cycles", 64'(valid_cycles), 64'd1);
    check("t3_data", 64'(last_data), 64'h00CCBBAA);
    check("t3_keep", 64'(last_keep), 64'b0111);

    // Flush with nothing held
    mark();
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_rd_en", 64'(rd_en), 64'd0);
    end
    check("t4_no_word", 64'(valid_cycles), 64'd0);

    // Flush in the cycle a read is issued, one lane held
    mark();
    fifo_q.push_back(8'h5A);
    for (int i = 0; i < 4; i++) step(0, 1, 0);
    fifo_q.push_back(8'hA5);
    step(1, 1, 0);
    check("t5_read_with_flush", 64'(rd_en), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 1, 0);
    check("t5_valid_cycles", 64'(valid_cycles), 64'd1);
    check("t5_data", 64'(last_data), 64'h0000A55A);
    check("t5_keep", 64'(last_keep), 64'b0011);

    // Reset with two lanes held
    mark();
    fifo_q = '{8'hE1, 8'hE2};
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    check("t6_busy_before", 64'(busy), 64'd1);
    fifo_q.push_back(8'hE3);
    step(0, 1, 1);
    check("t6_rd_en_in_reset", 64'(rd_en), 64'd0);
    step(0, 1, 1);
    check("t6_rst_valid", 64'(valid), 64'd0);
    check("t6_rst_data", 64'(data), 64'd0);
    check("t6_rst_keep", 64'(keep), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_rd_en", 64'(rd_en), 64'd0);
    mark();
    fifo_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    check("t6_valid_cycles", 64'(valid_cycles), 64'd1);
    check("t6_data", 64'(last_data), 64'h04030201);
    check("t6_keep", 64'(last_keep), 64'hF);

    // Randomized traffic, stalls, flushes and occasional reset
    for (int i = 0; i < 1500; i++) begin
      logic f, r, rs;
      if (fifo_q.size() < 6 && $urandom_range(0, 2) != 0)
        fifo_q.push_back(8'($urandom));
      r  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 24) == 0);
      rs = ($urandom_range(0, 499) == 0);
      step(f, r, rs);
    end
    for (int i = 0; i < 30; i++) step(0, 1, 0);
    step(1, 1, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0);
    check("drain_all_words_seen", 64'(exp_data_q.size()), 64'd0);
    check("drain_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
